imm_decode_stage: RTL
=====================

IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, legal values 32 or 64: immediate output width.
REQ-002 The module SHALL have parameter CNT_W, default 32: width of the decode counter.
REQ-003 The module SHALL have port clk  input  1  single clock, rising edge.
REQ-004 The module SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 The module SHALL have port flush  input  1  synchronous discard of all buffered entries.
REQ-006 The module SHALL have port in_valid  input  1  upstream instruction valid.
REQ-007 The module SHALL have port in_ready  output  1  stage can accept an instruction; registered.
REQ-008 The module SHALL have port in_inst  input  32  RISC-V instruction word.
REQ-009 The module SHALL have port out_valid  output  1  decoded entry available.
REQ-010 The module SHALL have port out_ready  input  1  downstream accepts the entry.
REQ-011 The module SHALL have port out_inst  output  32  instruction that accompanies out_imm.
REQ-012 The module SHALL have port out_imm  output  XLEN  sign-extended immediate.
REQ-013 The module SHALL have port out_fmt  output  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J.
REQ-014 The module SHALL have port decode_cnt  output  CNT_W  count of completed output transfers.
REQ-015 The module SHALL have port out_illegal  output  1  unrecognised opcode; present only with the macro in REQ-031.

Function
REQ-016 Opcode decode SHALL map to formats as follows:
- I: 0010011, 0000011, 1100111, plus 0011011 when XLEN=64.
- S: 0100011.
- B: 1100011.
- U: 0110111, 0010111.
- J: 1101111.
- Any other opcode: fmt NONE, imm 0.
REQ-017 Immediates SHALL use the standard bit fields, as follows:
- I: inst[31:20].
- S: {inst[31:25], inst[11:7]}.
- B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
- U: {inst[31:12], 12'h000}.
- J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
- All formats SHALL be sign-extended from the top bit to XLEN; U is sign-extended from bit 31 when XLEN=64.
REQ-018 Decode SHALL be performed on the input side, and the registered result SHALL be presented. Latency SHALL be one cycle from the in_valid&in_ready edge to out_valid.
REQ-019 The stage SHALL be a 2-entry in-order buffer with occupancy states EMPTY, ONE and TWO.
REQ-020 Transitions SHALL follow accept=in_valid&in_ready and drain=out_valid&out_ready:
- accept only: +1.
- drain only: -1.
- both: unchanged.
- neither: unchanged.
REQ-021 in_ready SHALL be 1 in EMPTY and ONE and 0 in TWO. Full throughput (one transfer per cycle) SHALL be sustained while out_ready=1.
REQ-022 out_valid SHALL be 1 exactly when the state is not EMPTY. out_* SHALL always show the oldest entry and SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 flush=1 SHALL set the state to EMPTY at the next edge and SHALL drop any same-cycle accept. A same-cycle drain still counts in decode_cnt.
REQ-024 decode_cnt SHALL increment by 1 on each drain and SHALL wrap from 2^CNT_W-1 to 0.
REQ-025 In the TWO state with drain, the oldest entry SHALL leave, the second entry SHALL become head, and in_ready SHALL rise at the next edge.

Reset
REQ-026 rst=1 SHALL asynchronously force the following, regardless of clk:
- state EMPTY.
- in_ready=1, out_valid=0.
- out_inst=0, out_imm=0, out_fmt=0.
- decode_cnt=0.
- out_illegal=0.
REQ-027 Assertion of rst mid-transfer SHALL discard all entries; no transfer SHALL occur on the edge at which rst deasserts.
REQ-028 Buffer payload registers other than the head outputs SHALL NOT require a reset.

Configuration
REQ-029 Macro IMM_ILLEGAL_CHECK_EN SHALL control illegal-opcode detection.
REQ-030 With IMM_ILLEGAL_CHECK_EN defined, out_illegal SHALL be stored per entry and SHALL be 1 when the head entry's opcode matches no row in REQ-016, or when inst[1:0]!=2'b11.
REQ-031 Without IMM_ILLEGAL_CHECK_EN, port out_illegal and its storage SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 The bench SHALL cover XLEN=32 with in_inst=0xFFF00093 (addi -1) and out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_fmt=1.
REQ-033 The bench SHALL cover back-to-back 0xFE112E23, 0xFE000CE3, 0x123450B7, 0x001000EF -> out_imm in order 0xFFFFFFFC (S), 0xFFFFFFF8 (B), 0x12345000 (U), 0x00000800 (J), one per cycle, with decode_cnt=4.
REQ-034 The bench SHALL cover out_ready=0 for 4 cycles while 3 instructions are offered -> 2 accepted, in_ready=0 after the second, and on out_ready=1 all 3 SHALL emerge in order with no loss or duplication.
REQ-035 The bench SHALL cover the TWO state with flush=1 and in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1, and decode_cnt unchanged.
REQ-036 The bench SHALL cover the illegal-opcode and XLEN=64 cases:
- With IMM_ILLEGAL_CHECK_EN and in_inst=0x0000007F -> out_illegal=1, out_fmt=0, out_imm=0.
- XLEN=64 with 0xFFF00093 -> out_imm=0xFFFFFFFFFFFFFFFF.

Source files
------------

// File: rtl/imm_decode_stage.sv
// RISC-V immediate decode stage: decodes on the input side into a 2-entry in-order buffer.
// Optional illegal-opcode flag per entry is enabled with `define IMM_ILLEGAL_CHECK_EN.
module imm_decode_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [CNT_W-1:0] decode_cnt
`ifdef IMM_ILLEGAL_CHECK_EN
    ,
    output logic             out_illegal
`endif
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } fmt_t;

    state_t            state, state_nxt;
    logic              accept, drain;
    logic              load_head, load_second, head_from_second;

    logic [31:0]       imm32;
    fmt_t              dec_fmt;
    logic [XLEN-1:0]   dec_imm;

    logic [31:0]       sec_inst;
    logic [XLEN-1:0]   sec_imm;
    logic [2:0]        sec_fmt;

`ifdef IMM_ILLEGAL_CHECK_EN
    logic              dec_illegal;
    logic              sec_illegal;
`endif

    // Decode the incoming word so the buffer only ever holds finished results.
    always_comb begin
        dec_fmt = FMT_NONE;
        imm32   = '0;
        case (in_inst[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
                dec_fmt = FMT_I;
                imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            7'b0011011: begin
                if (XLEN == 64) begin
                    dec_fmt = FMT_I;
                    imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
                end
            end
            7'b0100011: begin
                dec_fmt = FMT_S;
                imm32   = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            7'b1100011: begin
                dec_fmt = FMT_B;
                imm32   = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                           in_inst[30:25], in_inst[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt = FMT_U;
                imm32   = {in_inst[31:12], 12'h000};
            end
            7'b1101111: begin
                dec_fmt = FMT_J;
                imm32   = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                           in_inst[20], in_inst[30:21], 1'b0};
            end
            default: ;
        endcase
        dec_imm = XLEN'(signed'(imm32));
    end

`ifdef IMM_ILLEGAL_CHECK_EN
    assign dec_illegal = (dec_fmt == FMT_NONE) || (in_inst[1:0] != 2'b11);
`endif

    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready & ~flush;
    assign drain     = out_valid & out_ready;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt        = state;
        load_head        = 1'b0;
        load_second      = 1'b0;
        head_from_second = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt = ONE;
                    load_head = 1'b1;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    load_head = 1'b1;
                end else if (accept) begin
                    state_nxt   = TWO;
                    load_second = 1'b1;
                end else if (drain) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (drain) begin
                    state_nxt        = ONE;
                    head_from_second = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        if (flush) begin
            state_nxt = EMPTY;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            in_ready   <= 1'b1;
            decode_cnt <= '0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != TWO);
            if (drain) begin
                decode_cnt <= decode_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_inst    <= '0;
            out_imm     <= '0;
            out_fmt     <= '0;
`ifdef IMM_ILLEGAL_CHECK_EN
            out_illegal <= 1'b0;
`endif
        end else if (load_head) begin
            out_inst    <= in_inst;
            out_imm     <= dec_imm;
            out_fmt     <= dec_fmt;
`ifdef IMM_ILLEGAL_CHECK_EN
            out_illegal <= dec_illegal;
`endif
        end else if (head_from_second) begin
            out_inst    <= sec_inst;
            out_imm     <= sec_imm;
            out_fmt     <= sec_fmt;
`ifdef IMM_ILLEGAL_CHECK_EN
            out_illegal <= sec_illegal;
`endif
        end
    end

    // NOTE: the second slot is never visible while invalid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load_second) begin
            sec_inst    <= in_inst;
            sec_imm     <= dec_imm;
            sec_fmt     <= dec_fmt;
`ifdef IMM_ILLEGAL_CHECK_EN
            sec_illegal <= dec_illegal;
`endif
        end
    end

endmodule
